// File: rtl/uvmt_obi_st_slv_mem.sv
// rtl/uvmt_obi_st_slv_mem.sv - OBI responder memory with programmable latency and bounded outstanding responses
module uvmt_obi_st_slv_mem #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MEM_DEPTH       = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_LATENCY    = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   req,
  output logic                                   gnt,
  input  logic [ADDR_WIDTH-1:0]                  addr,
  input  logic                                   we,
  input  logic [DATA_WIDTH/8-1:0]                be,
  input  logic [DATA_WIDTH-1:0]                  wdata,
  input  logic [ID_WIDTH-1:0]                    aid,
  output logic                                   rvalid,
  input  logic                                   rready,
  output logic [DATA_WIDTH-1:0]                  rdata,
  output logic                                   err,
  output logic [ID_WIDTH-1:0]                    rid,
  output logic [$clog2(MAX_OUTSTANDING):0]       outstanding
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W    = $clog2(BE_WIDTH);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W    = $clog2(RESP_LATENCY) + 1;
  localparam int OCC_W    = $clog2(MAX_OUTSTANDING) + 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [DATA_WIDTH-1:0] f_rdata_q [MAX_OUTSTANDING];
  logic                  f_err_q   [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]   f_rid_q   [MAX_OUTSTANDING];
  logic [CNT_W-1:0]      f_cnt_q   [MAX_OUTSTANDING];
  logic                  f_vld_q   [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic                  accept, pop, oor;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_masked, wr_merged, push_rdata;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Slot freed by a same-cycle pop is deliberately not visible to this grant.
  assign gnt    = req & (occ_q < OCC_W'(MAX_OUTSTANDING));
  assign accept = req & gnt;
  assign idx    = addr[OFF_W +: IDX_W];
  assign oor    = (addr >> (OFF_W + IDX_W)) != '0;

  always_comb begin
    rd_masked = '0;
    wr_merged = mem_q[idx];
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (be[b]) begin
        rd_masked[b*8 +: 8] = mem_q[idx][b*8 +: 8];
        wr_merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  assign push_rdata = (!we && !oor) ? rd_masked : '0;

  assign rvalid      = f_vld_q[rd_ptr_q] && (f_cnt_q[rd_ptr_q] == '0);
  assign pop         = rvalid & rready;
  assign rdata       = rvalid ? f_rdata_q[rd_ptr_q] : '0;
  assign err         = rvalid ? f_err_q[rd_ptr_q]   : 1'b0;
  assign rid         = rvalid ? f_rid_q[rd_ptr_q]   : '0;
  assign outstanding = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (accept && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (!accept && pop) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (accept && we && !oor) begin
      mem_q[idx] <= wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        f_rdata_q[i] <= '0;
        f_err_q[i]   <= 1'b0;
        f_rid_q[i]   <= '0;
        f_cnt_q[i]   <= '0;
        f_vld_q[i]   <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (f_vld_q[i] && f_cnt_q[i] != '0) f_cnt_q[i] <= f_cnt_q[i] - CNT_W'(1);
      end
      if (pop) begin
        f_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_next(rd_ptr_q);
      end
      // Accept implies a free slot, so wr_ptr never collides with the popped head.
      if (accept) begin
        f_rdata_q[wr_ptr_q] <= push_rdata;
        f_err_q[wr_ptr_q]   <= oor;
        f_rid_q[wr_ptr_q]   <= aid;
        f_cnt_q[wr_ptr_q]   <= CNT_W'(RESP_LATENCY - 1);
        f_vld_q[wr_ptr_q]   <= 1'b1;
        wr_ptr_q            <= ptr_next(wr_ptr_q);
      end
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_uvmt_obi_st_slv_mem.sv
// tb/tb_uvmt_obi_st_slv_mem.sv - directed vector bench for uvmt_obi_st_slv_mem
module tb_uvmt_obi_st_slv_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 instance
  logic        rst1, req1, we1, rready1, gnt1, rvalid1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  be1, aid1, rid1;
  logic [2:0]  out1;

  // Latency-3 instance
  logic        rst3, req3, we3, rready3, gnt3, rvalid3, err3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  be3, aid3, rid3;
  logic [2:0]  out3;

  uvmt_obi_st_slv_mem #(.RESP_LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst1), .req(req1), .gnt(gnt1), .addr(addr1), .we(we1),
    .be(be1), .wdata(wdata1), .aid(aid1), .rvalid(rvalid1), .rready(rready1),
    .rdata(rdata1), .err(err1), .rid(rid1), .outstanding(out1)
  );

  uvmt_obi_st_slv_mem #(.RESP_LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst3), .req(req3), .gnt(gnt3), .addr(addr3), .we(we3),
    .be(be3), .wdata(wdata3), .aid(aid3), .rvalid(rvalid3), .rready(rready3),
    .rdata(rdata3), .err(err3), .rid(rid3), .outstanding(out3)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        rready;
    logic        e_gnt;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [3:0]  e_rid;
    logic [2:0]  e_out;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic rq, logic [31:0] a, logic w, logic [3:0] b, logic [31:0] wd,
                              logic [3:0] id, logic rr, logic eg, logic erv, logic [31:0] erd,
                              logic eerr, logic [3:0] erid, logic [2:0] eout);
    vec_t v;
    v.req = rq; v.addr = a; v.we = w; v.be = b; v.wdata = wd; v.aid = id; v.rready = rr;
    v.e_gnt = eg; v.e_rvalid = erv; v.e_rdata = erd; v.e_err = eerr; v.e_rid = erid; v.e_out = eout;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive1(input logic rq, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] wd, input logic [3:0] id, input logic rr);
    req1 = rq; addr1 = a; we1 = w; be1 = b; wdata1 = wd; aid1 = id; rready1 = rr;
  endtask

  task automatic drive3(input logic rq, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] wd, input logic [3:0] id, input logic rr);
    req3 = rq; addr3 = a; we3 = w; be3 = b; wdata3 = wd; aid3 = id; rready3 = rr;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  int exp_occ [6] = '{0, 1, 2, 3, 2, 1};

  initial begin
    // write/read, byte enables, range checks
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 0, 32'h0,        0, 0,  0));
    tbl.push_back(mk(1, 32'h10,       1, 4'hF, DB,           3,  1, 1, 0, 32'h0,        0, 0,  0));
    tbl.push_back(mk(1, 32'h10,       0, 4'hF, 32'h0,        5,  1, 1, 1, 32'h0,        0, 3,  1));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, DB,           0, 5,  1));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 0, 32'h0,        0, 0,  0));
    tbl.push_back(mk(1, 32'h20,       1, 4'hF, 32'h11223344, 1,  1, 1, 0, 32'h0,        0, 0,  0));
    tbl.push_back(mk(1, 32'h20,       1, 4'h5, 32'hAABBCCDD, 2,  1, 1, 1, 32'h0,        0, 1,  1));
    tbl.push_back(mk(1, 32'h20,       0, 4'hF, 32'h0,        3,  1, 1, 1, 32'h0,        0, 2,  1));
    tbl.push_back(mk(1, 32'h20,       0, 4'h3, 32'h0,        4,  1, 1, 1, 32'h11BB33DD, 0, 3,  1));
    tbl.push_back(mk(1, 32'h400,      0, 4'hF, 32'h0,        6,  1, 1, 1, 32'h000033DD, 0, 4,  1));
    tbl.push_back(mk(1, 32'h10,       0, 4'hF, 32'h0,        7,  1, 1, 1, 32'h0,        1, 6,  1));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, DB,           0, 7,  1));
    tbl.push_back(mk(1, 32'h80000010, 0, 4'hF, 32'h0,        8,  1, 1, 0, 32'h0,        0, 0,  0));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, 32'h0,        1, 8,  1));
    tbl.push_back(mk(1, 32'h400,      1, 4'hF, 32'hFFFFFFFF, 9,  1, 1, 0, 32'h0,        0, 0,  0));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, 32'h0,        1, 9,  1));
    tbl.push_back(mk(1, 32'h13,       0, 4'hF, 32'h0,        10, 1, 1, 0, 32'h0,        0, 0,  0));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, DB,           0, 10, 1));
    tbl.push_back(mk(1, 32'h0,        0, 4'hF, 32'h0,        11, 1, 1, 0, 32'h0,        0, 0,  0));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, 32'h0,        0, 11, 1));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 0, 32'h0,        0, 0,  0));
    // backpressure until full, single-cycle pop, then drain
    tbl.push_back(mk(1, 32'h10,       0, 4'hF, 32'h0,        1,  0, 1, 0, 32'h0,        0, 0,  0));
    tbl.push_back(mk(1, 32'h10,       0, 4'hF, 32'h0,        2,  0, 1, 1, DB,           0, 1,  1));
    tbl.push_back(mk(1, 32'h10,       0, 4'hF, 32'h0,        3,  0, 1, 1, DB,           0, 1,  2));
    tbl.push_back(mk(1, 32'h10,       0, 4'hF, 32'h0,        4,  0, 1, 1, DB,           0, 1,  3));
    tbl.push_back(mk(1, 32'h10,       0, 4'hF, 32'h0,        5,  0, 0, 1, DB,           0, 1,  4));
    tbl.push_back(mk(1, 32'h10,       0, 4'hF, 32'h0,        5,  1, 0, 1, DB,           0, 1,  4));
    tbl.push_back(mk(1, 32'h10,       0, 4'hF, 32'h0,        5,  0, 1, 1, DB,           0, 2,  3));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  0, 0, 1, DB,           0, 2,  4));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, DB,           0, 2,  4));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, DB,           0, 3,  3));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, DB,           0, 4,  2));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 1, DB,           0, 5,  1));
    tbl.push_back(mk(0, 32'h0,        0, 4'h0, 32'h0,        0,  1, 0, 0, 32'h0,        0, 0,  0));

    rst1 = 1'b1; rst3 = 1'b1;
    drive1(0, 0, 0, 0, 0, 0, 1);
    drive3(0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive1(tbl[i].req, tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].wdata, tbl[i].aid, tbl[i].rready);
      #1;
      chk($sformatf("v%0d gnt", i),    32'(gnt1),   32'(tbl[i].e_gnt));
      chk($sformatf("v%0d rvalid", i), 32'(rvalid1), 32'(tbl[i].e_rvalid));
      chk($sformatf("v%0d rdata", i),  rdata1,      tbl[i].e_rdata);
      chk($sformatf("v%0d err", i),    32'(err1),   32'(tbl[i].e_err));
      chk($sformatf("v%0d rid", i),    32'(rid1),   32'(tbl[i].e_rid));
      chk($sformatf("v%0d outst", i),  32'(out1),   32'(tbl[i].e_out));
    end

    // latency 3: write response appears exactly three cycles after grant
    @(negedge clk);
    drive3(1, 32'h0, 1, 4'hF, 32'hCAFE0000, 9, 1);
    #1 chk("l3 wr gnt", 32'(gnt3), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive3(0, 0, 0, 0, 0, 0, 1);
      #1;
      chk($sformatf("l3 wr rvalid c%0d", c), 32'(rvalid3), 32'(c == 3));
      chk($sformatf("l3 wr rid c%0d", c),    32'(rid3),    (c == 3) ? 32'd9 : 32'd0);
    end

    // latency 3: back-to-back reads return back-to-back, in order
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 3) drive3(1, 32'h0, 0, 4'hF, 32'h0, 4'(c + 1), 1);
      else       drive3(0, 0, 0, 0, 0, 0, 1);
      #1;
      if (c < 3) chk($sformatf("l3 rd gnt c%0d", c), 32'(gnt3), 32'd1);
      chk($sformatf("l3 rd rvalid c%0d", c), 32'(rvalid3), 32'(c >= 3));
      chk($sformatf("l3 rd rid c%0d", c),    32'(rid3),    (c >= 3) ? 32'(c - 2) : 32'd0);
      chk($sformatf("l3 rd rdata c%0d", c),  rdata3,       (c >= 3) ? 32'hCAFE0000 : 32'd0);
      chk($sformatf("l3 rd outst c%0d", c),  32'(out3),    32'(exp_occ[c]));
    end
    @(negedge clk);
    #1 chk("l3 drained", 32'(out3), 32'd0);

    // reset with two responses pending
    @(negedge clk);
    drive1(1, 32'h10, 0, 4'hF, 32'h0, 1, 0);
    @(negedge clk);
    drive1(1, 32'h10, 0, 4'hF, 32'h0, 2, 0);
    #1 chk("rst pre outst1", 32'(out1), 32'd1);
    @(negedge clk);
    drive1(0, 0, 0, 0, 0, 0, 0);
    rst1 = 1'b1;
    #1 chk("rst pre outst2", 32'(out1), 32'd2);
    @(negedge clk);
    rst1 = 1'b0;
    drive1(1, 32'h10, 0, 4'hF, 32'h0, 4, 1);
    #1;
    chk("rst rvalid", 32'(rvalid1), 32'd0);
    chk("rst outst",  32'(out1),    32'd0);
    chk("rst rid",    32'(rid1),    32'd0);
    @(negedge clk);
    drive1(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst rd rvalid", 32'(rvalid1), 32'd1);
    chk("rst rd rid",    32'(rid1),    32'd4);
    chk("rst rd rdata",  rdata1,       32'd0);
    @(negedge clk);
    #1 chk("rst final outst", 32'(out1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
